// File: rtl/nibble_mux_sched.sv
// nibble_mux_sched
//
// Round-robin scheduler for two requesters that share one nibble-select mux.
// A granted requester's operand pair is latched and evaluated in a registered
// EXEC cycle:
//     lo = sel[0] ? B[3:0] : A[3:0]
//     hi = sel[1] ? B[7:4] : lo
//     C  = {hi, lo}
// where sel is the latched A[1:0]. The tagged result is then offered on a
// valid/ready port. If the result waits too long, it is dropped and a sticky
// error flag is raised.
//
// Optional macro NMS_SEL_OVERRIDE_EN adds two ports, cfg_sel_en and cfg_sel.
// When cfg_sel_en is high during EXEC, cfg_sel replaces A[1:0] as the select.
//
// Parameters:
//   TIMEOUT     cycles a result may wait in OUT for res_ready (0 = never drop)
//   CNT_W       timeout counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid[1:0]           per-requester operand pair offered
//   req_ready[1:0]           one-hot accept pulse (combinational, IDLE only)
//   req0_a/b, req1_a/b       operand pairs (A[1:0] doubles as select)
//   res_valid/res_ready      result handshake
//   res_data, res_id         mux result and owning requester
//   busy                     transaction in flight
//   err_timeout, err_clr     sticky dropped-result flag and its clear
//   cfg_sel_en, cfg_sel      select override (NMS_SEL_OVERRIDE_EN only)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate; pulse req_ready to the winner and latch its operands
// EXEC  | evaluate the mux, register result and id, raise res_valid
// OUT   | hold the result until accepted or timed out

module nibble_mux_sched #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       busy,
    output logic       err_timeout,
    input  logic       err_clr
`ifdef NMS_SEL_OVERRIDE_EN
    ,
    input  logic       cfg_sel_en,
    input  logic [1:0] cfg_sel
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // A timeout fires in the OUT cycle whose counter value is TIMEOUT-1.
    // With TIMEOUT=0, the compare is forced off.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             rr_ptr;
    logic [3:0]       op_a_lo;
    logic [7:0]       op_b;
    logic             op_id;
    logic [CNT_W-1:0] cnt;

    logic             gnt_any;
    logic             gnt_id;
    logic [1:0]       sel;
    logic [3:0]       mux_lo;
    logic [3:0]       mux_hi;
    logic             to_hit;
    logic             to_evt;

    // Only A[3:0] feeds the datapath; A[7:4] never reaches C.
    logic unused_a_hi;
    assign unused_a_hi = ^{req0_a[7:4], req1_a[7:4]};

    // Grant: a lone requester wins outright. On a tie, rr_ptr decides.
    always_comb begin
        gnt_any   = |req_valid;
        gnt_id    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
        req_ready = 2'b00;
        if (state == S_IDLE && gnt_any) begin
            req_ready = gnt_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        sel = op_a_lo[1:0];
`ifdef NMS_SEL_OVERRIDE_EN
        if (cfg_sel_en) begin
            sel = cfg_sel;
        end
`endif
        mux_lo = sel[0] ? op_b[3:0] : op_a_lo;
        mux_hi = sel[1] ? op_b[7:4] : mux_lo;
    end

    assign to_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign to_evt = (state == S_OUT) && !res_ready && to_hit;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= 1'b0;
            op_a_lo     <= 4'h0;
            op_b        <= 8'h00;
            op_id       <= 1'b0;
            cnt         <= '0;
            res_valid   <= 1'b0;
            res_data    <= 8'h00;
            res_id      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        op_a_lo <= gnt_id ? req1_a[3:0] : req0_a[3:0];
                        op_b    <= gnt_id ? req1_b : req0_b;
                        op_id   <= gnt_id;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_data  <= {mux_hi, mux_lo};
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    cnt       <= '0;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    // Whether accepted or dropped, the owner loses the next tie.
                    if (res_ready || to_hit) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= ~res_id;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A timeout in the same cycle as err_clr wins.
            if (to_evt) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule
